// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
package imem_boot_loader_pkg;

  // Capacity of the instruction memory in 32-bit words (4 KB).
  localparam int unsigned IMEM_DEPTH_WORDS = 1024;

  // Canonical RISC-V NOP (addi x0, x0, 0); fetch logic can feed this
  // into the pipeline while core_rst is held.
  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  // Boot loader control states.
  typedef enum logic [2:0] {
    HDR_LO = 3'd0,
    HDR_HI = 3'd1,
    LOAD   = 3'd2,
    DONE   = 3'd3,
    ERR    = 3'd4
  } boot_state_e;

endpackage

// File: rtl/imem_boot_loader_packer.sv
// Byte-to-word packer: gathers four stream bytes little-endian into a
// 32-bit word and presents it for exactly one cycle after the fourth byte.
module imem_boot_loader_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [1:0]  byte_idx,
  output logic        word_valid,
  output logic [31:0] word_data
);

  logic [23:0] asm_q, asm_d;
  logic [1:0]  idx_q, idx_d;
  logic        valid_q, valid_d;
  logic [31:0] data_q, data_d;

  // Shift each byte in from the top so the first byte ends up in [7:0];
  // the fourth byte completes the word, which is then held until the next.
  always_comb begin
    asm_d   = asm_q;
    idx_d   = idx_q;
    valid_d = 1'b0;
    data_d  = data_q;
    if (byte_valid) begin
      idx_d = idx_q + 2'd1;
      if (idx_q == 2'd3) begin
        data_d  = {byte_data, asm_q};
        valid_d = 1'b1;
      end else begin
        asm_d = {byte_data, asm_q[23:8]};
      end
    end
  end

  // Assembly and output registers; reset discards any partial word.
  always_ff @(posedge clk) begin
    if (rst) begin
      asm_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      asm_q   <= asm_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign byte_idx   = idx_q;
  assign word_valid = valid_q;
  assign word_data  = data_q;

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: parses a length header from a byte stream, writes the
// following words into instruction memory and releases the core afterwards.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = IMEM_DEPTH_WORDS,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        mem_we,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic        core_rst,
  output logic        boot_done,
  output logic        boot_err,
  output logic [15:0] word_cnt
);

  // The whole image window must land inside the memory's index range.
  localparam longint unsigned LAST_BYTE =
    longint'(BASE_ADDR) + 64'd4 * (longint'(DEPTH_WORDS) - 64'd1);
  localparam bit PARAMS_LEGAL = (BASE_ADDR[1:0] == 2'b00) &&
                                (DEPTH_WORDS >= 1) && (DEPTH_WORDS <= 65535) &&
                                (LAST_BYTE < 64'd4 * longint'(IMEM_DEPTH_WORDS));

  generate
    if (!PARAMS_LEGAL) begin : g_param_check
      $error("imem_boot_loader: BASE_ADDR/DEPTH_WORDS exceed instruction memory");
    end
  endgenerate

  localparam logic [16:0] DEPTH_LIMIT = 17'(DEPTH_WORDS);

  boot_state_e state_q, state_d;
  logic [15:0] n_q, n_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic [31:0] waddr_q, waddr_d;
  logic        armed_q, armed_d;

  logic        accept;
  logic        pk_byte_valid;
  logic [1:0]  pk_byte_idx;
  logic        pk_word_valid;
  logic [31:0] pk_word_data;
  logic [15:0] hdr_len;

  assign hdr_len = {in_data, n_q[7:0]};

  // Ready only after reset has been released for one edge, and in LOAD
  // only until the last word's bytes have all arrived.
  always_comb begin
    in_ready = 1'b0;
    if (armed_q) begin
      case (state_q)
        HDR_LO, HDR_HI: in_ready = 1'b1;
        LOAD:           in_ready = (word_cnt_q != n_q);
        default:        in_ready = 1'b0;
      endcase
    end
  end

  assign accept        = in_valid && in_ready;
  assign pk_byte_valid = accept && (state_q == LOAD);

  imem_boot_loader_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (pk_byte_valid),
    .byte_data  (in_data),
    .byte_idx   (pk_byte_idx),
    .word_valid (pk_word_valid),
    .word_data  (pk_word_data)
  );

  // Next-state logic: header capture, word counting and write addressing.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    word_cnt_d = word_cnt_q;
    waddr_d    = waddr_q;
    armed_d    = 1'b1;
    case (state_q)
      HDR_LO: begin
        if (accept) begin
          n_d[7:0] = in_data;
          state_d  = HDR_HI;
        end
      end
      HDR_HI: begin
        if (accept) begin
          n_d = hdr_len;
          if ({1'b0, hdr_len} > DEPTH_LIMIT) begin
            state_d = ERR;
          end else if (hdr_len == 16'd0) begin
            state_d = DONE;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (word_cnt_q == n_q) begin
          state_d = DONE;
        end else if (accept && (pk_byte_idx == 2'd3)) begin
          word_cnt_d = word_cnt_q + 16'd1;
          waddr_d    = BASE_ADDR + {14'd0, word_cnt_q, 2'b00};
        end
      end
      DONE:    state_d = DONE;
      ERR:     state_d = ERR;
      default: state_d = HDR_LO;
    endcase
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HDR_LO;
      n_q        <= '0;
      word_cnt_q <= '0;
      waddr_q    <= BASE_ADDR;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      word_cnt_q <= word_cnt_d;
      waddr_q    <= waddr_d;
      armed_q    <= armed_d;
    end
  end

  assign mem_we    = pk_word_valid;
  assign mem_waddr = waddr_q;
  assign mem_wdata = pk_word_data;
  assign word_cnt  = word_cnt_q;
  assign boot_done = (state_q == DONE);
  assign boot_err  = (state_q == ERR);
  assign core_rst  = (state_q != DONE);

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: directed image loads with a
// write-strobe scoreboard fed as payload is driven.
module tb_imem_boot_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int READY_LIMIT   = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'h00;
  logic        mem_we;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic        core_rst;
  logic        boot_done;
  logic        boot_err;
  logic [15:0] word_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  imem_boot_loader #(
    .DEPTH_WORDS (1024),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .core_rst  (core_rst),
    .boot_done (boot_done),
    .boot_err  (boot_err),
    .word_cnt  (word_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every write strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [63:0] e;
    if (mem_we !== 1'b0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {31'd0, mem_we}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("strobe_addr", mem_waddr, e[63:32]);
        check("strobe_data", mem_wdata, e[31:0]);
      end
    end
  end

  // Present one byte after an idle gap and hold it until it transfers.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    waited   = 0;
    while (in_ready !== 1'b1 && waited < READY_LIMIT) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= READY_LIMIT) begin
      n_checks++;
      n_fail++;
      $error("FAIL ready_timeout: observed in_ready=%b expected 1 within %0d cycles", in_ready, READY_LIMIT);
    end else begin
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic send_header(input logic [15:0] n, input int maxgap);
    send_byte(n[7:0],  $urandom_range(0, maxgap));
    send_byte(n[15:8], $urandom_range(0, maxgap));
  endtask

  task automatic send_word(input logic [31:0] w, input int idx, input int maxgap);
    logic [31:0] addr;
    addr = BASE + 32'(idx) * 32'd4;
    exp_q.push_back({addr, w});
    send_byte(w[7:0],   $urandom_range(0, maxgap));
    send_byte(w[15:8],  $urandom_range(0, maxgap));
    send_byte(w[23:16], $urandom_range(0, maxgap));
    send_byte(w[31:24], $urandom_range(0, maxgap));
  endtask

  task automatic do_reset(input int cycles);
    in_valid = 1'b0;
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    check("rst_in_ready",  {31'd0, in_ready},  32'd0);
    check("rst_mem_we",    {31'd0, mem_we},    32'd0);
    check("rst_mem_waddr", mem_waddr,          BASE);
    check("rst_mem_wdata", mem_wdata,          32'd0);
    check("rst_core_rst",  {31'd0, core_rst},  32'd1);
    check("rst_boot_done", {31'd0, boot_done}, 32'd0);
    check("rst_boot_err",  {31'd0, boot_err},  32'd0);
    check("rst_word_cnt",  {16'd0, word_cnt},  32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst_low", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check("ready_rises", {31'd0, in_ready}, 32'd1);
  endtask

  // Two-word image: addi x0,x0,0 then addi x1,x0,1.
  task automatic load_two_words(input int maxgap);
    send_header(16'd2, maxgap);
    send_word(32'h0000_0013, 0, maxgap);
    send_word(32'h0010_0093, 1, maxgap);
    check("done_not_yet",     {31'd0, boot_done}, 32'd0);
    check("core_rst_not_yet", {31'd0, core_rst},  32'd1);
    @(negedge clk);
    check("done_after_strobe", {31'd0, boot_done}, 32'd1);
    check("core_rst_released", {31'd0, core_rst},  32'd0);
    check("ready_low_done",    {31'd0, in_ready},  32'd0);
    check("word_cnt_two",      {16'd0, word_cnt},  32'd2);
    check("sb_empty_two",      exp_q.size(),       32'd0);
    check("waddr_hold",        mem_waddr,          BASE + 32'd4);
    check("wdata_hold",        mem_wdata,          32'h0010_0093);
  endtask

  initial begin
    // Scenario 1: back-to-back two-word image.
    do_reset(3);
    load_two_words(0);

    // Scenario 2: empty image.
    do_reset(2);
    send_header(16'd0, 0);
    check("empty_done",     {31'd0, boot_done}, 32'd1);
    check("empty_core_rst", {31'd0, core_rst},  32'd0);
    check("empty_ready",    {31'd0, in_ready},  32'd0);
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (3) @(negedge clk);
    check("empty_ready_hold", {31'd0, in_ready}, 32'd0);
    check("empty_word_cnt",   {16'd0, word_cnt}, 32'd0);
    in_valid = 1'b0;

    // Scenario 3: same image with random valid gaps.
    do_reset(2);
    load_two_words(5);

    // Scenario 4: oversized header, then recovery.
    do_reset(2);
    send_header(16'h0401, 0);
    check("err_flag",     {31'd0, boot_err},  32'd1);
    check("err_ready",    {31'd0, in_ready},  32'd0);
    check("err_core_rst", {31'd0, core_rst},  32'd1);
    check("err_done",     {31'd0, boot_done}, 32'd0);
    in_valid = 1'b1;
    in_data  = 8'h13;
    repeat (6) @(negedge clk);
    check("err_sticky", {31'd0, boot_err}, 32'd1);
    in_valid = 1'b0;
    do_reset(1);
    load_two_words(0);

    // Scenario 5: reset in the middle of a load.
    do_reset(2);
    send_header(16'd3, 0);
    send_word(32'h0050_0113, 0, 0);
    send_byte(8'h77, 0);
    check("partial_word_cnt", {16'd0, word_cnt}, 32'd1);
    check("partial_sb_empty", exp_q.size(),      32'd0);
    do_reset(1);
    load_two_words(0);

    // Scenario 6: maximum-size image, word i holds i.
    do_reset(2);
    send_header(16'h0400, 0);
    for (int i = 0; i < 1024; i++) begin
      send_word(32'(i), i, 0);
    end
    check("max_last_waddr", mem_waddr, 32'h0000_0FFC);
    check("max_last_wdata", mem_wdata, 32'h0000_03FF);
    check("max_done_not_yet", {31'd0, boot_done}, 32'd0);
    @(negedge clk);
    check("max_done",     {31'd0, boot_done}, 32'd1);
    check("max_core_rst", {31'd0, core_rst},  32'd0);
    check("max_word_cnt", {16'd0, word_cnt},  32'd1024);
    check("max_sb_empty", exp_q.size(),       32'd0);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    repeat (4) @(negedge clk);
    check("trailing_not_ready", {31'd0, in_ready}, 32'd0);
    check("trailing_word_cnt",  {16'd0, word_cnt}, 32'd1024);
    in_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Boot-time controller for the 4 KB instruction memory (1024 x 32-bit, word-indexed by address[11:2]).
- Receives a byte stream (UART/JTAG bridge or testbench), assembles little-endian 32-bit words and drives the memory's write port.
- Holds the 5-stage core in reset until the image is fully written, so synthesis no longer depends on $readmemh preload.

Parameters:
- DEPTH_WORDS, 1024, instruction memory capacity in words; upper bound on the image length.
- BASE_ADDR, 32'h0000_0000, byte address of the first image word.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  byte-stream valid.
- in_ready  out  1  byte-stream ready; a byte transfers when in_valid && in_ready at the clock edge.
- in_data  in  8  stream byte.
- mem_we  out  1  instruction-memory write strobe, one cycle per word.
- mem_waddr  out  32  byte address of the write, word aligned.
- mem_wdata  out  32  write data.
- core_rst  out  1  reset to the pipeline; high until the load completes.
- boot_done  out  1  image fully written.
- boot_err  out  1  header length exceeded DEPTH_WORDS.
- word_cnt  out  16  number of words written so far.

Behaviour:
- Reset values: state=HDR_LO, in_ready=0, mem_we=0, mem_waddr=BASE_ADDR, mem_wdata=0, core_rst=1, boot_done=0, boot_err=0, word_cnt=0, byte index=0.
- in_ready rises the cycle after rst deasserts.
- Stream format: 2-byte header N (word count, low byte first), then 4*N payload bytes. Each word is little-endian: the first byte maps to [7:0], the fourth to [31:24].
- State HDR_LO: accept a byte into N[7:0], then go to HDR_HI.
- State HDR_HI: accept a byte into N[15:8], then:
  - if N > DEPTH_WORDS, go to ERR;
  - else if N == 0, go to DONE;
  - else go to LOAD.
- State LOAD:
  - Accept bytes into a 24-bit shift/assembly register plus a 2-bit byte index.
  - On accepting byte index 3, the next cycle asserts mem_we=1 for exactly one cycle with:
    - mem_waddr = BASE_ADDR + 4*word_cnt;
    - mem_wdata = the assembled word.
  - word_cnt increments in that same write cycle; the byte index wraps 3->0.
  - in_ready stays high during the write cycle. A byte accepted then becomes byte 0 of the next word, so there is no bubble.
- After the write of word N-1, the state goes to DONE on the following edge.
- State DONE:
  - in_ready=0, boot_done=1, core_rst=0.
  - The core's first fetch happens the cycle after core_rst falls.
  - Terminal until rst; further bytes are ignored (not accepted).
- State ERR:
  - in_ready=0, boot_err=1, core_rst stays 1, mem_we never asserted.
  - Terminal until rst.
- Backpressure: in_valid gaps of any length are allowed in any state. No state advance occurs without a transfer.
- Latency: the write strobe occurs 1 cycle after the 4th byte of a word; boot_done occurs 1 cycle after the final write strobe.
- Reset mid-load:
  - Returns to HDR_LO and clears word_cnt and the partial word; core_rst=1 again.
  - Words already written stay in memory but are considered invalid.
- Address arithmetic: 32-bit with wrap. BASE_ADDR + 4*(DEPTH_WORDS-1) must fit the memory's index bits; this is a parameter-legality check, not a runtime check.
- N == DEPTH_WORDS is legal: the last write goes to index DEPTH_WORDS-1.
- mem_waddr and mem_wdata hold their last values outside write cycles.

Decomposition:
- Shared package:
  - state encoding localparams (HDR_LO, HDR_HI, LOAD, DONE, ERR);
  - IMEM_DEPTH_WORDS=1024;
  - RV_NOP=32'h0000_0013, for fetch-side use while core_rst=1.
- Optional sub-module byte_to_word_packer:
  - owns the 24-bit assembly register and byte index;
  - emits word_valid/word_data.
- The top-level FSM owns the header, counting and core_rst.

Test Plan:
1. Header 02 00, payload 13 00 00 00 93 00 10 00 streamed back-to-back -> mem_we pulses with (addr 0x0, data 0x00000013) then (addr 0x4, data 0x00100093); word_cnt=2; boot_done=1 and core_rst=0 one cycle after the second pulse.
2. Header 00 00 -> no mem_we; DONE the cycle after the second header byte; in_ready=0 thereafter.
3. Same image as scenario 1 with random 0-5 cycle in_valid gaps -> identical writes and data; no duplicate or missing strobes.
4. Header 01 04 (N=1025) -> boot_err=1, in_ready=0, core_rst=1, no mem_we; then rst pulse with a valid image -> normal load.
5. Header 03 00 and 5 payload bytes, then rst for 1 cycle, then image from scenario 1 -> first load writes exactly one word; after reset word_cnt restarts at 0 and the writes match scenario 1.
6. Header 00 04 (N=1024, the maximum) with pattern data = index -> last strobe has addr 0xFFC and data 0x000003FF; boot_done asserted; an extra trailing byte is not accepted.
